// File: rtl/faddsub_pipe_if.sv
// Operand/result bundle for the pipelined adder/subtractor.
// The master side issues operands and the slave side returns registered results.
interface faddsub_pipe_if #(
    parameter int WIDTH = 16
);
    logic             ce;
    logic             vi;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bi;
    logic [WIDTH-1:0] s;
    logic             bout;
    logic             ovf;
    logic             vo;

    modport master (
        output ce, vi, mode, a, b, bi,
        input  s, bout, ovf, vo
    );

    modport slave (
        input  ce, vi, mode, a, b, bi,
        output s, bout, ovf, vo
    );
endinterface

// File: rtl/faddsub_pipe.sv
// Pipelined ripple adder/subtractor, split into STAGES segments of SEG bits.
// Rank k adds segment k using the registered carry of rank k-1.
// Operands skew forward through the ranks alongside their MODE and valid bit.
// Finished low segments ride along in s_q so the whole result leaves together.
module faddsub_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input logic           ck,
    input logic           lsr,
    faddsub_pipe_if.slave bus
);
    localparam int SEG = WIDTH / STAGES;

    // pipeline ranks
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             m_q [STAGES];
    logic             c_q [STAGES];
    logic             v_q [STAGES];
    logic             ovf_q;

    // what each rank sees on its inputs
    logic [WIDTH-1:0] in_a [STAGES];
    logic [WIDTH-1:0] in_b [STAGES];
    logic [WIDTH-1:0] in_s [STAGES];
    logic             in_m [STAGES];
    logic             in_c [STAGES];
    logic             in_v [STAGES];

    logic [SEG-1:0]   seg_a   [STAGES];
    logic [SEG-1:0]   seg_b   [STAGES];
    logic [SEG:0]     seg_sum [STAGES];
    logic [WIDTH-1:0] nxt_s   [STAGES];
    logic             nxt_ovf;

    // Rank 0 takes the bus; every later rank takes the previous rank's registers.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            in_a[k] = '0;
            in_b[k] = '0;
            in_s[k] = '0;
            in_m[k] = 1'b0;
            in_c[k] = 1'b0;
            in_v[k] = 1'b0;
        end
        in_a[0] = bus.a;
        in_b[0] = bus.b;
        in_m[0] = bus.mode;
        in_c[0] = bus.bi;
        in_v[0] = bus.vi;
        for (int k = 1; k < STAGES; k++) begin
            in_a[k] = a_q[k-1];
            in_b[k] = b_q[k-1];
            in_s[k] = s_q[k-1];
            in_m[k] = m_q[k-1];
            in_c[k] = c_q[k-1];
            in_v[k] = v_q[k-1];
        end
    end

    // Segment adders; subtraction inverts B per segment so MODE can change every op.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            seg_a[k]   = in_a[k][k*SEG +: SEG];
            seg_b[k]   = in_m[k] ? ~in_b[k][k*SEG +: SEG] : in_b[k][k*SEG +: SEG];
            seg_sum[k] = {1'b0, seg_a[k]} + {1'b0, seg_b[k]} + {{SEG{1'b0}}, in_c[k]};
            nxt_s[k]   = in_s[k];
            nxt_s[k][k*SEG +: SEG] = seg_sum[k][SEG-1:0];
        end
        // carry out of the msb xor carry into it; the latter is recovered from the sum bit
        nxt_ovf = seg_sum[STAGES-1][SEG] ^ seg_sum[STAGES-1][SEG-1]
                ^ seg_a[STAGES-1][SEG-1] ^ seg_b[STAGES-1][SEG-1];
    end

    // Pipeline registers: reset wins over ce, ce=0 freezes every rank.
    always_ff @(posedge ck) begin
        if (lsr) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                m_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (bus.ce) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= in_a[k];
                b_q[k] <= in_b[k];
                s_q[k] <= nxt_s[k];
                m_q[k] <= in_m[k];
                c_q[k] <= seg_sum[k][SEG];
                v_q[k] <= in_v[k];
            end
            ovf_q <= nxt_ovf;
        end
    end

    assign bus.s    = s_q[STAGES-1];
    assign bus.bout = c_q[STAGES-1];
    assign bus.ovf  = ovf_q;
    assign bus.vo   = v_q[STAGES-1];
endmodule

// File: tb/tb_faddsub_pipe.sv
// Bench for faddsub_pipe: directed vectors, stall/reset sequences on STAGES=2,
// and a random sweep over STAGES=1,2,4,16 against an arithmetic model.
module tb_faddsub_pipe;
    localparam int W = 16;

    logic ck = 1'b0;
    logic lsr;
    always #5 ck = ~ck;

    faddsub_pipe_if #(.WIDTH(W)) if1 ();
    faddsub_pipe_if #(.WIDTH(W)) if2 ();
    faddsub_pipe_if #(.WIDTH(W)) if4 ();
    faddsub_pipe_if #(.WIDTH(W)) if16 ();

    faddsub_pipe #(.WIDTH(W), .STAGES(1))  u1  (.ck(ck), .lsr(lsr), .bus(if1));
    faddsub_pipe #(.WIDTH(W), .STAGES(2))  u2  (.ck(ck), .lsr(lsr), .bus(if2));
    faddsub_pipe #(.WIDTH(W), .STAGES(4))  u4  (.ck(ck), .lsr(lsr), .bus(if4));
    faddsub_pipe #(.WIDTH(W), .STAGES(16)) u16 (.ck(ck), .lsr(lsr), .bus(if16));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         mode;
        logic         bi;
        logic [W-1:0] s;
        logic         bout;
        logic         ovf;
        string        name;
    } vec_t;

    typedef struct packed {
        logic        vi;
        logic [17:0] r;
    } rec_t;

    vec_t vecs [11];
    rec_t q [$];

    // Reference: plain integer arithmetic, returns {ovf, bout, s}.
    function automatic logic [17:0] ref_op(logic [W-1:0] a, logic [W-1:0] b, logic mode, logic bi);
        logic [W-1:0] bx;
        int           u;
        int           sa;
        int           sb;
        int           sv;
        logic         ov;
        bx = mode ? ~b : b;
        u  = 0;
        u  = u + a + bx + bi;
        sa = $signed(a);
        sb = $signed(bx);
        sv = sa + sb + int'(bi);
        ov = (sv > 32767) || (sv < -32768);
        return {ov, u[16], u[15:0]};
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic drv2(logic ce, logic vi, logic mode, logic [W-1:0] a, logic [W-1:0] b, logic bi);
        if2.ce = ce; if2.vi = vi; if2.mode = mode; if2.a = a; if2.b = b; if2.bi = bi;
    endtask

    task automatic drv_all(logic ce, logic vi, logic mode, logic [W-1:0] a, logic [W-1:0] b, logic bi);
        if1.ce  = ce; if1.vi  = vi; if1.mode  = mode; if1.a  = a; if1.b  = b; if1.bi  = bi;
        if4.ce  = ce; if4.vi  = vi; if4.mode  = mode; if4.a  = a; if4.b  = b; if4.bi  = bi;
        if16.ce = ce; if16.vi = vi; if16.mode = mode; if16.a = a; if16.b = b; if16.bi = bi;
        drv2(ce, vi, mode, a, b, bi);
    endtask

    // Check the STAGES=2 instance against an expected valid flag and {ovf,bout,s}.
    task automatic exp2(string nm, logic vo, logic [17:0] r);
        chk({nm, "_vo"}, 32'(if2.vo), 32'(vo));
        if (vo) begin
            chk({nm, "_s"},    32'(if2.s),    32'(r[15:0]));
            chk({nm, "_bout"}, 32'(if2.bout), 32'(r[16]));
            chk({nm, "_ovf"},  32'(if2.ovf),  32'(r[17]));
        end
    endtask

    // Sweep check: output after n enabled edges reflects the op sampled st edges ago.
    task automatic chk_sw(string nm, int st, logic vo, logic [W-1:0] s, logic bout, logic ovf);
        rec_t r;
        int   n;
        n = q.size();
        if (n >= st) begin
            r = q[n-st];
            chk({nm, "_vo"}, 32'(vo), 32'(r.vi));
            if (r.vi) begin
                chk({nm, "_s"},    32'(s),    32'(r.r[15:0]));
                chk({nm, "_bout"}, 32'(bout), 32'(r.r[16]));
                chk({nm, "_ovf"},  32'(ovf),  32'(r.r[17]));
            end
        end else begin
            chk({nm, "_vo_fill"}, 32'(vo), 32'd0);
        end
    endtask

    initial begin
        logic [17:0] r0, r2, r3;
        vecs[0]  = '{16'h1234, 16'h0034, 1'b1, 1'b1, 16'h1200, 1'b1, 1'b0, "sub_basic"};
        vecs[1]  = '{16'h0100, 16'h0001, 1'b1, 1'b1, 16'h00FF, 1'b1, 1'b0, "sub_seg_borrow"};
        vecs[2]  = '{16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, "sub_wrap"};
        vecs[3]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf"};
        vecs[4]  = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf"};
        vecs[5]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, "add_seg_carry"};
        vecs[6]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_wrap"};
        vecs[7]  = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, "add_cin"};
        vecs[8]  = '{16'h0005, 16'h0003, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, "sub_borrow_in"};
        vecs[9]  = '{16'h7FFF, 16'hFFFF, 1'b1, 1'b1, 16'h8000, 1'b0, 1'b1, "sub_neg_ovf"};
        vecs[10] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, "add_min_ovf"};

        // reset state
        lsr = 1'b1;
        drv_all(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        tick();
        chk("rst_vo",   32'(if2.vo),   32'd0);
        chk("rst_s",    32'(if2.s),    32'd0);
        chk("rst_bout", 32'(if2.bout), 32'd0);
        chk("rst_ovf",  32'(if2.ovf),  32'd0);
        lsr = 1'b0;
        drv_all(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        drv2(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        tick();

        // directed table, one op at a time, latency exactly two
        for (int i = 0; i < 11; i++) begin
            drv2(1'b1, 1'b1, vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].bi);
            tick();
            chk({vecs[i].name, "_early_vo"}, 32'(if2.vo), 32'd0);
            drv2(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
            tick();
            chk({vecs[i].name, "_vo"},   32'(if2.vo),   32'd1);
            chk({vecs[i].name, "_s"},    32'(if2.s),    32'(vecs[i].s));
            chk({vecs[i].name, "_bout"}, 32'(if2.bout), 32'(vecs[i].bout));
            chk({vecs[i].name, "_ovf"},  32'(if2.ovf),  32'(vecs[i].ovf));
        end
        tick();

        // mixed-mode stream 1,0,1,1 with a three-cycle stall
        r0 = ref_op(16'h1111, 16'h2222, 1'b0, 1'b0);
        r2 = ref_op(16'h5000, 16'h1000, 1'b1, 1'b1);
        r3 = ref_op(16'h0FFF, 16'h0001, 1'b0, 1'b0);
        drv2(1'b1, 1'b1, 1'b0, 16'h1111, 16'h2222, 1'b0);
        tick();
        exp2("st_e1", 1'b0, r0);
        drv2(1'b1, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
        tick();
        exp2("st_e2", 1'b1, r0);
        for (int i = 0; i < 3; i++) begin
            drv2(1'b0, 1'b1, 1'b1, 16'hDEAD, 16'hBEEF, 1'b0);
            tick();
            exp2("st_hold", 1'b1, r0);
        end
        drv2(1'b1, 1'b1, 1'b1, 16'h5000, 16'h1000, 1'b1);
        tick();
        exp2("st_e3", 1'b0, r0);
        drv2(1'b1, 1'b1, 1'b0, 16'h0FFF, 16'h0001, 1'b0);
        tick();
        exp2("st_e4", 1'b1, r2);
        drv2(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        tick();
        exp2("st_e5", 1'b1, r3);
        tick();
        exp2("st_e6", 1'b0, r3);

        // reset with two ops in flight, and ce low during reset
        drv2(1'b1, 1'b1, 1'b0, 16'h4321, 16'h1111, 1'b0);
        tick();
        lsr = 1'b1;
        drv2(1'b0, 1'b1, 1'b1, 16'h7777, 16'h0001, 1'b1);
        tick();
        lsr = 1'b0;
        chk("mrst_vo",   32'(if2.vo),   32'd0);
        chk("mrst_s",    32'(if2.s),    32'd0);
        chk("mrst_bout", 32'(if2.bout), 32'd0);
        chk("mrst_ovf",  32'(if2.ovf),  32'd0);
        drv2(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        tick();
        exp2("mrst_gone1", 1'b0, r0);
        tick();
        exp2("mrst_gone2", 1'b0, r0);
        r0 = ref_op(16'hABCD, 16'h0123, 1'b1, 1'b1);
        drv2(1'b1, 1'b1, 1'b1, 16'hABCD, 16'h0123, 1'b1);
        tick();
        exp2("post_rst_e1", 1'b0, r0);
        drv2(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        tick();
        exp2("post_rst_e2", 1'b1, r0);

        // random sweep over all depths, same stream into every instance
        lsr = 1'b1;
        tick();
        lsr = 1'b0;
        q.delete();
        for (int i = 0; i < 400; i++) begin
            logic         ce, vi, mode, bi;
            logic [W-1:0] a, b;
            rec_t         rec;
            ce   = ($urandom_range(0, 3) != 0);
            vi   = ($urandom_range(0, 4) != 0);
            mode = 1'($urandom_range(0, 1));
            bi   = 1'($urandom_range(0, 1));
            a    = 16'($urandom);
            b    = 16'($urandom);
            drv_all(ce, vi, mode, a, b, bi);
            rec.vi = vi;
            rec.r  = ref_op(a, b, mode, bi);
            tick();
            if (ce) q.push_back(rec);
            chk_sw("sw1",  1,  if1.vo,  if1.s,  if1.bout,  if1.ovf);
            chk_sw("sw2",  2,  if2.vo,  if2.s,  if2.bout,  if2.ovf);
            chk_sw("sw4",  4,  if4.vo,  if4.s,  if4.bout,  if4.ovf);
            chk_sw("sw16", 16, if16.vo, if16.s, if16.bout, if16.ovf);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/faddsub_pipe.md
FADDSUB_PIPE -- requirements
Module: faddsub_pipe

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width in bits; SHALL be at least 2.
REQ-002 Parameter STAGES, default 2, number of pipeline register ranks; SHALL be at least 1 and SHALL divide WIDTH exactly. SEG = WIDTH/STAGES bits per stage.
REQ-003 Reset: one clock; reset is synchronous and active-high. Ports: CK input 1, rising-edge clock; LSR input 1, reset.
REQ-004 CE  input  1  clock enable; 0 freezes every pipeline register.
REQ-005 VI  input  1  input operands valid.
REQ-006 MODE  input  1  1 = subtract, 0 = add; sampled with operands.
REQ-007 A  input  WIDTH  minuend or addend, two's complement or unsigned.
REQ-008 B  input  WIDTH  subtrahend or addend.
REQ-009 BI  input  1  carry-in; in subtract mode 1 = no borrow-in, 0 = borrow-in.
REQ-010 S  output  WIDTH  registered result.
REQ-011 BOUT  output  1  registered carry-out; in subtract mode 1 = no borrow-out, 0 = borrow-out.
REQ-012 OVF  output  1  registered signed overflow of the full-width result.
REQ-013 VO  output  1  result valid, aligned with S/BOUT/OVF.

Function
REQ-014 Add mode SHALL compute {BOUT,S} = A + B + BI; subtract mode SHALL compute {BOUT,S} = A + ~B + BI, i.e. S = A - B - (1-BI) modulo 2^WIDTH.
REQ-015 Stage k (0..STAGES-1) SHALL process bits k*SEG .. k*SEG+SEG-1, taking its carry from stage k-1's registered carry and bit 0 from BI.
REQ-016 Operand bits not yet consumed SHALL travel through skew registers; finished result segments SHALL travel through de-skew registers so all WIDTH bits of S appear in the same cycle.
REQ-017 MODE SHALL travel with its operands; operations of different MODE SHALL be issuable back-to-back with no bubble.
REQ-018 Latency SHALL be exactly STAGES enabled CK edges from VI=1 sampled to VO=1; throughput one operation per enabled cycle.
REQ-019 OVF SHALL equal the XOR of the carries into and out of bit WIDTH-1 of the final stage, for both modes.
REQ-020 VI=0 SHALL insert a bubble: VO=0 at the corresponding output cycle; data registers SHALL still load (values don't-care when VO=0).
REQ-021 CE=0 SHALL hold all data, carry, MODE and valid registers, including VO, unchanged; no operation is lost or duplicated across a CE stall of any length.
REQ-022 STAGES=1 SHALL degenerate to a single registered WIDTH-bit adder/subtractor with latency 1.
REQ-023 Wrap-around: results SHALL be modulo 2^WIDTH, with overflow reported only via BOUT and OVF and never saturated.

Reset
REQ-024 LSR=1 at a CK edge SHALL clear all valid bits so VO=0 the following cycle; S=0, BOUT=0, OVF=0.
REQ-025 LSR SHALL take priority over CE; reset with CE=0 still clears.
REQ-026 Reset mid-operation SHALL discard every in-flight operation; the first VI after LSR deasserts SHALL produce VO exactly STAGES enabled cycles later.

Verification (WIDTH=16, STAGES=2 unless stated)
REQ-027 Sub: A=0x1234, B=0x0034, BI=1 -> 2 cycles later S=0x1200, BOUT=1, OVF=0, VO=1.
REQ-028 Sub borrow across segment boundary: A=0x0100, B=0x0001, BI=1 -> S=0x00FF, BOUT=1; then A=0x0000, B=0x0001, BI=1 -> S=0xFFFF, BOUT=0, OVF=0.
REQ-029 Overflow: add A=0x7FFF, B=0x0001, BI=0 -> S=0x8000, OVF=1, BOUT=0; sub A=0x8000, B=0x0001, BI=1 -> S=0x7FFF, OVF=1, BOUT=1.
REQ-030 Back-to-back mixed MODE with VI pattern 1,0,1,1 and CE=0 for 3 cycles mid-stream -> results in order, VO pattern 1,0,1,1 shifted by 2 enabled cycles, no duplicates.
REQ-031 LSR asserted with 2 operations in flight -> VO=0 next cycle, neither result emerges; new op after release appears at latency 2.
REQ-032 Sweep STAGES=1,4,16 with random operands -> every result matches the reference add/sub model at latency STAGES.
